d_delay_line: RTL and testbench
===============================

# d_delay_line

Parametrised multi-channel D-register delay line: CH independent W-bit channels travel together through a DEPTH-stage flip-flop pipeline with per-stage valid tracking. It adds the following on top of the single-bit D storage element:
- a clock enable (hold/advance);
- a valid-only flush;
- a runtime-selectable output tap;
- an occupancy count;
- a complemented output.

It sits between producers and consumers needing fixed, programmable alignment delay of grouped data.

## Interface
Parameters:
- W, 8: data width per channel, ≥1.
- CH, 2: channel count, ≥1.
- DEPTH, 4: pipeline stages, ≥1.
- RESET_VAL, 0: W-bit value loaded into every channel of every stage on reset.

Ports (TW = DEPTH>1 ? clog2(DEPTH) : 1; OW = clog2(DEPTH+1)):
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-low.
- en  input  1  advance enable; 0 = every stage holds.
- flush  input  1  clears all stage valid bits.
- vin  input  1  valid qualifier for din.
- din  input  CH*W  channel c occupies bits [c*W +: W].
- tap  input  TW  selects stage driven onto dout/vout.
- dout  output  CH*W  data of selected stage.
- dout_n  output  CH*W  bitwise ~dout.
- vout  output  1  valid bit of selected stage.
- occ  output  OW  number of stages holding valid data.
- full  output  1  occ == DEPTH.

## Operation
- State: stages s[0..DEPTH-1], each holding CH*W data plus one valid bit; occ register.
- Per rising clk edge, priority order:
  - 1. rst==0: all stage data = RESET_VAL replicated per channel; all valid = 0; occ = 0.
  - 2. flush==1: all valid = 0, occ = 0; stage data unchanged; no shift even if en==1.
  - 3. en==1: s[0] <= {din, vin}; s[i] <= s[i-1] for i = 1..DEPTH-1; stage DEPTH-1 contents are discarded.
  - 4. otherwise: all stages hold.
- occ: registered count of valid bits after the update. On a shift it changes by +vin − valid(s[DEPTH-1]) (range 0..DEPTH).
- full is combinational from occ.
- Output select:
  - dout/vout = s[tap] (combinational mux from stage registers).
  - tap ≥ DEPTH selects s[DEPTH-1] (saturating).
- dout is never zeroed for invalid stages. Consumers must qualify with vout.
- dout_n = ~dout at all times, including reset.
- Channels are fully independent bit-slices. No cross-channel arithmetic.
- DEPTH==1: tap is ignored; occ is 1 bit wide.

## Timing
- Latency for a sample presented with en=1: appears on dout after tap+1 enabled edges. Cycles with en=0 add no latency count.
- tap change takes effect combinationally in the same cycle (no register).
- Reset is only sampled on clk edges; mid-operation reset takes effect at the next edge with rst==0, overriding flush/en.
- Reset values, from the first edge with rst==0:
  - dout = RESET_VAL per channel; dout_n = ~RESET_VAL per channel;
  - vout = 0; occ = 0; full = 0.
- Before the first reset edge, outputs are X.
- flush+en same edge: flush wins; din/vin are dropped.
- en with vin=0 inserts a bubble (valid 0, data still captured).
- Full pipeline with en=1 keeps shifting; the oldest entry is dropped silently. No backpressure.

## Test plan
- Reset: W=8, CH=2, DEPTH=4, RESET_VAL=8'hA5, hold rst=0 for 2 edges. Expected: dout=16'hA5A5, dout_n=16'h5A5A, vout=0, occ=0, full=0.
- Latency sweep, tap=0..3, en=1, inject one valid din=16'h1234:
  - vout pulses exactly tap+1 edges after injection, with dout=16'h1234;
  - dout_n=16'hEDCB.
- Stall: inject 16'h0102, then en=0 for 3 cycles, then en=1, tap=1. Expected: sample appears 2 enabled edges after injection; occ stays 1 during the stall.
- Fill, flush, reset:
  - 4 valid inputs with en=1: occ=4, full=1.
  - 5th valid input: occ stays 4; the first sample leaves.
  - flush=1 with en=1: occ=0, vout=0, data unchanged, no shift.
  - rst=0 asserted mid-stream: everything returns to reset values next edge.
- Boundary:
  - tap=7 with DEPTH=5 (TW=3): behaves as tap=4.
  - DEPTH=1 build: 1-edge latency, tap ignored.
  - Alternating vin=1/0 bubbles: occ tracks the exact valid count each edge.

Source files
------------

// File: rtl/d_delay_line_if.sv
// Bus bundle for d_delay_line: control, data in, tap select and all outputs.
// Latency: none, signal grouping only.
// Backpressure: none; the line always accepts data when enabled.
// Ports (master drives): en, flush, vin, din[CH*W], tap[TW].
// Ports (slave drives):  dout[CH*W], dout_n[CH*W], vout, occ[OW], full.
interface d_delay_line_if #(
    parameter int W     = 8,
    parameter int CH    = 2,
    parameter int DEPTH = 4
);
    localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic              en;
    logic              flush;
    logic              vin;
    logic [CH*W-1:0]   din;
    logic [TW-1:0]     tap;
    logic [CH*W-1:0]   dout;
    logic [CH*W-1:0]   dout_n;
    logic              vout;
    logic [OW-1:0]     occ;
    logic              full;

    modport master (
        output en, flush, vin, din, tap,
        input  dout, dout_n, vout, occ, full
    );

    modport slave (
        input  en, flush, vin, din, tap,
        output dout, dout_n, vout, occ, full
    );
endinterface

// File: rtl/d_delay_line.sv
// Multi-channel DEPTH-stage delay line with per-stage valid, flush, runtime output tap and occupancy.
// Latency: tap+1 enabled edges from din to dout; tap change is seen combinationally.
// Backpressure: none; when full and enabled the oldest entry is silently dropped.
// Ports: clk, rst (synchronous, active-low), bus (slave modport of d_delay_line_if).
module d_delay_line #(
    parameter int             W         = 8,
    parameter int             CH        = 2,
    parameter int             DEPTH     = 4,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic           clk,
    input  logic           rst,
    d_delay_line_if.slave  bus
);
    localparam int DW = CH * W;
    localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [DW-1:0]    sdat [DEPTH];
    logic [DEPTH-1:0] svld;
    logic [OW-1:0]    occ_q;
    logic [OW-1:0]    occ_nxt;
    logic [DW-1:0]    rst_word;
    logic [TW-1:0]    sel;
    logic [DW-1:0]    dout_sel;
    logic             vld_sel;

    assign rst_word = {CH{RESET_VAL}};

    // Modular arithmetic: the intermediate may wrap, the final count is always 0..DEPTH.
    always_comb begin
        occ_nxt = occ_q + OW'(bus.vin) - OW'(svld[DEPTH-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sdat[i] <= rst_word;
            end
            svld  <= '0;
            occ_q <= '0;
        end else if (bus.flush) begin
            // Valid-only clear: data stays put and nothing shifts this edge.
            svld  <= '0;
            occ_q <= '0;
        end else if (bus.en) begin
            sdat[0] <= bus.din;
            svld[0] <= bus.vin;
            for (int i = 1; i < DEPTH; i++) begin
                sdat[i] <= sdat[i-1];
                svld[i] <= svld[i-1];
            end
            occ_q <= occ_nxt;
        end
    end

    // Saturating tap: any value past the last stage reads the last stage.
    always_comb begin
        sel = bus.tap;
        if (DEPTH == 1) begin
            sel = '0;
        end else if (int'(bus.tap) > DEPTH - 1) begin
            sel = TW'(DEPTH - 1);
        end
    end

    always_comb begin
        dout_sel = sdat[0];
        vld_sel  = svld[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (sel == TW'(i)) begin
                dout_sel = sdat[i];
                vld_sel  = svld[i];
            end
        end
    end

    assign bus.dout   = dout_sel;
    assign bus.dout_n = ~dout_sel;
    assign bus.vout   = vld_sel;
    assign bus.occ    = occ_q;
    assign bus.full   = (occ_q == OW'(DEPTH));
endmodule

// File: tb/tb_d_delay_line.sv
// Bench for d_delay_line: three builds (DEPTH 4, 5, 1) share one stimulus stream.
// The reference keeps a history of accepted samples indexed by enabled-edge count.
module tb_d_delay_line;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, flush, vin;
    logic [15:0] din;
    logic [1:0]  tap_a;
    logic [2:0]  tap_b;
    logic        tap_c;
    int          checks = 0;
    int          errors = 0;

    d_delay_line_if #(.W(8), .CH(2), .DEPTH(4)) ia ();
    d_delay_line_if #(.W(8), .CH(2), .DEPTH(5)) ib ();
    d_delay_line_if #(.W(8), .CH(2), .DEPTH(1)) ic ();

    assign ia.en = en;  assign ia.flush = flush;  assign ia.vin = vin;  assign ia.din = din;  assign ia.tap = tap_a;
    assign ib.en = en;  assign ib.flush = flush;  assign ib.vin = vin;  assign ib.din = din;  assign ib.tap = tap_b;
    assign ic.en = en;  assign ic.flush = flush;  assign ic.vin = vin;  assign ic.din = din;  assign ic.tap = tap_c;

    d_delay_line #(.W(8), .CH(2), .DEPTH(4), .RESET_VAL(8'hA5)) u_a (.clk(clk), .rst(rst), .bus(ia));
    d_delay_line #(.W(8), .CH(2), .DEPTH(5), .RESET_VAL(8'h0F)) u_b (.clk(clk), .rst(rst), .bus(ib));
    d_delay_line #(.W(8), .CH(2), .DEPTH(1), .RESET_VAL(8'hC3)) u_c (.clk(clk), .rst(rst), .bus(ic));

    typedef struct packed {
        logic [15:0] dout;
        logic        vout;
        logic [3:0]  occ;
        logic        full;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    // History of samples: entry k is the sample accepted on the k-th enabled edge.
    // Entries at or before 'base' were wiped by reset; at or before 'fmark' were flushed.
    logic [15:0] hist_d [0:4095];
    bit          hist_v [0:4095];
    int          n = 0;
    int          base = 0;
    int          fmark = 0;

    task automatic model_edge();
        if (!rst) begin
            base = n;
        end else if (flush) begin
            fmark = n;
        end else if (en) begin
            n++;
            hist_d[n] = din;
            hist_v[n] = vin;
        end
    endtask

    function automatic bit is_valid(int idx);
        if (idx <= base || idx <= fmark) return 1'b0;
        return hist_v[idx];
    endfunction

    function automatic exp_t exp_of(int depth, logic [7:0] rv, int tap);
        exp_t e;
        int   eff, idx, cnt;
        eff    = (tap > depth - 1) ? depth - 1 : tap;
        idx    = n - eff;
        e.dout = {rv, rv};
        e.vout = 1'b0;
        if (idx > base) begin
            e.dout = hist_d[idx];
            e.vout = is_valid(idx);
        end
        cnt = 0;
        for (int i = 0; i < depth; i++) begin
            if (is_valid(n - i)) cnt++;
        end
        e.occ  = 4'(cnt);
        e.full = (cnt == depth);
        return e;
    endfunction

    task automatic cmp(string nm, exp_t e, logic [15:0] d, logic [15:0] dn, logic v, logic [3:0] o, logic f);
        checks++;
        if (d !== e.dout || dn !== ~e.dout || v !== e.vout || o !== e.occ || f !== e.full) begin
            errors++;
            $display("FAIL %s @%0t: got dout=%h dout_n=%h vout=%b occ=%0d full=%b, want dout=%h dout_n=%h vout=%b occ=%0d full=%b",
                     nm, $time, d, dn, v, o, f, e.dout, ~e.dout, e.vout, e.occ, e.full);
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, want);
        end
    endtask

    // Monitor: every output cycle is compared against the expectation queued for it.
    always @(negedge clk) begin
        if (q_a.size() > 0) cmp("depth4", q_a.pop_front(), ia.dout, ia.dout_n, ia.vout, 4'(ia.occ), ia.full);
        if (q_b.size() > 0) cmp("depth5", q_b.pop_front(), ib.dout, ib.dout_n, ib.vout, 4'(ib.occ), ib.full);
        if (q_c.size() > 0) cmp("depth1", q_c.pop_front(), ic.dout, ic.dout_n, ic.vout, 4'(ic.occ), ic.full);
    end

    // One clock edge: inputs are already stable; the expectation is queued right after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        q_a.push_back(exp_of(4, 8'hA5, int'(tap_a)));
        q_b.push_back(exp_of(5, 8'h0F, int'(tap_b)));
        q_c.push_back(exp_of(1, 8'hC3, int'(tap_c)));
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; flush = 1'b0; vin = 1'b0; din = '0;
        tap_a = '0; tap_b = '0; tap_c = '0;

        // Reset held for two edges.
        step();
        step();
        chk("reset_dout",   32'(ia.dout),   32'h0000A5A5);
        chk("reset_dout_n", 32'(ia.dout_n), 32'h00005A5A);
        chk("reset_vout",   32'(ia.vout),   32'h0);
        chk("reset_occ",    32'(ia.occ),    32'h0);
        chk("reset_full",   32'(ia.full),   32'h0);
        rst = 1'b1;

        // Latency sweep: one valid sample, then bubbles.
        for (int t = 0; t < 4; t++) begin
            tap_a = 2'(t);
            en = 1'b1; vin = 1'b1; din = 16'h1234;
            step();
            vin = 1'b0; din = 16'h0000;
            for (int j = 1; j <= 4; j++) begin
                chk($sformatf("lat_t%0d_e%0d_vout", t, j), 32'(ia.vout), 32'(j == t + 1));
                if (j == t + 1) begin
                    chk($sformatf("lat_t%0d_dout", t),   32'(ia.dout),   32'h1234);
                    chk($sformatf("lat_t%0d_dout_n", t), 32'(ia.dout_n), 32'hEDCB);
                end
                step();
            end
        end

        // Stall: enable low holds the sample in stage 0.
        flush = 1'b1; step(); flush = 1'b0;
        chk("stall_pre_occ", 32'(ia.occ), 32'h0);
        tap_a = 2'd1; vin = 1'b1; din = 16'h0102;
        step();
        vin = 1'b0; en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stall%0d_occ", k),  32'(ia.occ),  32'h1);
            chk($sformatf("stall%0d_vout", k), 32'(ia.vout), 32'h0);
        end
        en = 1'b1;
        step();
        chk("stall_out_vout", 32'(ia.vout), 32'h1);
        chk("stall_out_dout", 32'(ia.dout), 32'h0102);

        // Fill, overflow, flush with enable, mid-stream reset.
        flush = 1'b1; step(); flush = 1'b0;
        vin = 1'b1; tap_a = 2'd3;
        for (int i = 1; i <= 4; i++) begin
            din = 16'hA000 + 16'(i);
            step();
        end
        chk("fill_occ",  32'(ia.occ),  32'h4);
        chk("fill_full", 32'(ia.full), 32'h1);
        chk("fill_dout", 32'(ia.dout), 32'hA001);
        din = 16'hA005; step();
        chk("over_occ",  32'(ia.occ),  32'h4);
        chk("over_dout", 32'(ia.dout), 32'hA002);
        flush = 1'b1; din = 16'hBEEF; step(); flush = 1'b0;
        chk("flush_occ",  32'(ia.occ),  32'h0);
        chk("flush_vout", 32'(ia.vout), 32'h0);
        chk("flush_dout", 32'(ia.dout), 32'hA002);
        din = 16'hC0DE; step();
        rst = 1'b0; step(); rst = 1'b1;
        chk("midrst_dout", 32'(ia.dout), 32'h0000A5A5);
        chk("midrst_occ",  32'(ia.occ),  32'h0);

        // Saturating tap on DEPTH=5 and the single-stage build.
        tap_b = 3'd7; tap_c = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 16'h5100 + 16'(i);
            step();
        end
        chk("tap7_dout", 32'(ib.dout), 32'h5100);
        chk("tap7_vout", 32'(ib.vout), 32'h1);
        chk("d1_dout",   32'(ic.dout), 32'h5104);
        chk("d1_vout",   32'(ic.vout), 32'h1);

        // Alternating bubbles.
        flush = 1'b1; step(); flush = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            vin = k[0];
            din = 16'($urandom);
            step();
        end
        chk("bubble_occ", 32'(ia.occ), 32'h2);

        // Randomized traffic including occasional flush and reset.
        for (int k = 0; k < 1500; k++) begin
            rst   = ($urandom % 100) != 0;
            flush = ($urandom % 20) == 0;
            en    = ($urandom % 4) != 0;
            vin   = 1'($urandom);
            din   = 16'($urandom);
            tap_a = 2'($urandom);
            tap_b = 3'($urandom);
            tap_c = 1'($urandom);
            step();
        end
        rst = 1'b1; flush = 1'b0; en = 1'b0;
        step();
        @(negedge clk);
        chk("queue_drain", 32'(q_a.size() + q_b.size() + q_c.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
